// File: rtl/loop_uhat_sparse_mul_pipe.sv
// ---------------------------------------------------------------------------
// loop_uhat_sparse_mul_pipe
//   Pipelined multiplier for the loop_uhat_sparse datapath, with configurable
//   latency, per-operand runtime signedness, a valid/clear tag pipeline and an
//   optional multiply-accumulate mode. A low clock enable freezes every
//   register, including valid tags and the accumulator.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   ce         clock enable for the whole pipe
//   in_valid   din0/din1/signed0/signed1/acc_clr qualify this cycle
//   din0       operand A, DIN0_WIDTH bits
//   din1       operand B, DIN1_WIDTH bits
//   signed0    1 = din0 is two's complement
//   signed1    1 = din1 is two's complement
//   acc_clr    ACC_EN=1: restart accumulation with this beat (ignored otherwise)
//   dout       product (ACC_EN=0) or running accumulator (ACC_EN=1)
//   out_valid  dout holds the result of a valid beat
// ---------------------------------------------------------------------------
module loop_uhat_sparse_mul_pipe #(
    parameter int DIN0_WIDTH = 71,
    parameter int DIN1_WIDTH = 4,
    parameter int DOUT_WIDTH = 75,
    parameter int NUM_STAGE  = 5,
    parameter int ACC_EN     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  signed0,
    input  logic                  signed1,
    input  logic                  acc_clr,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_valid
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2;

    if (NUM_STAGE < 2 || NUM_STAGE > 16) begin : g_bad_num_stage
        $error("loop_uhat_sparse_mul_pipe: NUM_STAGE must be within 2..16");
    end

    // ---------------- Stage 1: operand capture ----------------
    logic [DIN0_WIDTH-1:0] a_q;
    logic [DIN1_WIDTH-1:0] b_q;
    logic                  sa_q;
    logic                  sb_q;
    logic                  v1_q;
    logic                  c1_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            v1_q <= 1'b0;
            c1_q <= 1'b0;
        end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            sa_q <= signed0;
            sb_q <= signed1;
            v1_q <= in_valid;
            // The clear tag is dead weight in plain-multiply mode.
            c1_q <= acc_clr & (ACC_EN != 0);
        end
    end

    // ---------------- Product ----------------
    // One extra bit per operand lets a single signed multiplier cover every
    // signedness combination: the extension bit is the msb only when signed.
    logic signed [DIN0_WIDTH:0]   a_ext;
    logic signed [DIN1_WIDTH:0]   b_ext;
    logic signed [PROD_WIDTH-1:0] prod_full;
    logic        [DOUT_WIDTH-1:0] prod;

    assign a_ext     = {sa_q & a_q[DIN0_WIDTH-1], a_q};
    assign b_ext     = {sb_q & b_q[DIN1_WIDTH-1], b_q};
    assign prod_full = PROD_WIDTH'(a_ext) * PROD_WIDTH'(b_ext);
    // Signed size cast: sign-extends when DOUT is wider, keeps LSBs otherwise.
    assign prod      = DOUT_WIDTH'(prod_full);

    // ---------------- Retiming delay line ----------------
    // fin_* is what the final stage samples: the product directly for a
    // two-stage pipe, otherwise the tail of NUM_STAGE-2 delay registers.
    logic [DOUT_WIDTH-1:0] fin_data;
    logic                  fin_valid;
    logic                  fin_clr;

    if (NUM_STAGE <= 2) begin : g_no_delay
        assign fin_data  = prod;
        assign fin_valid = v1_q;
        assign fin_clr   = c1_q;
    end else begin : g_delay
        localparam int DEPTH = NUM_STAGE - 2;

        logic [DOUT_WIDTH-1:0] d_data [DEPTH];
        logic [DEPTH-1:0]      d_valid;
        logic [DEPTH-1:0]      d_clr;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                // NOTE: the data array sits on the async reset as well, so a
                // reset leaves no stale product anywhere in the pipe.
                for (int i = 0; i < DEPTH; i++) d_data[i] <= '0;
                d_valid <= '0;
                d_clr   <= '0;
            end else if (ce) begin
                d_data[0]  <= prod;
                d_valid[0] <= v1_q;
                d_clr[0]   <= c1_q;
                for (int i = 1; i < DEPTH; i++) begin
                    d_data[i]  <= d_data[i-1];
                    d_valid[i] <= d_valid[i-1];
                    d_clr[i]   <= d_clr[i-1];
                end
            end
        end

        assign fin_data  = d_data[DEPTH-1];
        assign fin_valid = d_valid[DEPTH-1];
        assign fin_clr   = d_clr[DEPTH-1];
    end

    // ---------------- Final stage: output / accumulator ----------------
    // In MAC mode dout is the accumulator itself; the clear tag arrives with
    // its own beat, so a clear lands exactly on that beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= fin_valid;
            if (ACC_EN == 0) begin
                dout <= fin_data;
            end else if (fin_clr) begin
                dout <= fin_valid ? fin_data : '0;
            end else if (fin_valid) begin
                dout <= dout + fin_data;
            end
        end
    end

endmodule
